// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Extracts command frames (HEADER, CMD, LEN, PAYLOAD[LEN], CHK) from the
//   byte stream of a UART receiver. Length and 8-bit additive checksum
//   (CMD + LEN + payload, modulo 256) are verified, and a stalled frame is
//   aborted after an inter-byte gap of TIMEOUT_BYTES byte times.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx_done      one-cycle strobe, byte valid on rx_data
//   rx_data      received byte
//   rd_addr      payload buffer read address
//   rd_data      payload byte at rd_addr (1-cycle registered read)
//   frame_valid  one-cycle pulse, good frame committed
//   frame_cmd    CMD of the last good frame
//   frame_len    LEN of the last good frame
//   frame_err    one-cycle pulse, frame aborted
//   err_code     reason for the last abort: 1 checksum, 2 length, 3 timeout
//   busy         high while a frame is in progress
module uart_frame_parser #(
  parameter int          CLK_FREQ      = 50000000,
  parameter int          UART_BPS      = 115200,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int          MAX_LEN       = 16,
  parameter int          TIMEOUT_BYTES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       frame_valid,
  output logic [7:0] frame_cmd,
  output logic [4:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int TIMEOUT_CYC = TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS);
  localparam int TO_W        = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      cmd_r, cmd_nxt;
  logic [4:0]      len_r, len_nxt;
  logic [7:0]      sum_r, sum_nxt;
  logic [3:0]      idx_r, idx_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            valid_nxt, err_nxt;
  logic [1:0]      code_nxt;
  logic [7:0]      fcmd_nxt;
  logic [4:0]      flen_nxt;
  logic            buf_we;
  logic [7:0]      buf_mem [0:15];

  // A byte arriving on the expiry cycle clears the counter and is processed,
  // so the timeout only fires on a cycle without rx_done.
  assign timeout_hit = (state != S_IDLE) && (to_cnt == TO_LAST) && !rx_done;
  assign busy        = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_r;
    len_nxt   = len_r;
    sum_nxt   = sum_r;
    idx_nxt   = idx_r;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    fcmd_nxt  = frame_cmd;
    flen_nxt  = frame_len;
    buf_we    = 1'b0;
    if (rx_done) begin
      case (state)
        S_IDLE: begin
          if (rx_data == HEADER) state_nxt = S_CMD;
        end
        S_CMD: begin
          cmd_nxt   = rx_data;
          sum_nxt   = rx_data;
          state_nxt = S_LEN;
        end
        S_LEN: begin
          len_nxt = rx_data[4:0];
          if (rx_data > MAX_LEN_B) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'd2;
            state_nxt = S_IDLE;
          end else begin
            sum_nxt = sum_r + rx_data;
            idx_nxt = 4'd0;
            state_nxt = (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          buf_we  = 1'b1;
          sum_nxt = sum_r + rx_data;
          idx_nxt = idx_r + 4'd1;
          if ({1'b0, idx_r} == (len_r - 5'd1)) state_nxt = S_CHK;
        end
        S_CHK: begin
          state_nxt = S_IDLE;
          if (rx_data == sum_r) begin
            valid_nxt = 1'b1;
            fcmd_nxt  = cmd_r;
            flen_nxt  = len_r;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = 2'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      err_nxt   = 1'b1;
      code_nxt  = 2'd3;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_r       <= 8'd0;
      len_r       <= 5'd0;
      sum_r       <= 8'd0;
      idx_r       <= 4'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      frame_cmd   <= 8'd0;
      frame_len   <= 5'd0;
    end else begin
      state       <= state_nxt;
      cmd_r       <= cmd_nxt;
      len_r       <= len_nxt;
      sum_r       <= sum_nxt;
      idx_r       <= idx_nxt;
      frame_valid <= valid_nxt;
      frame_err   <= err_nxt;
      err_code    <= code_nxt;
      frame_cmd   <= fcmd_nxt;
      frame_len   <= flen_nxt;
    end
  end

  // Inter-byte gap counter: counts every cycle without a byte while a frame
  // is open; held at zero in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (rx_done || state == S_IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[idx_r] <= rx_data;
  end

  // Registered read port; a same-cycle write to rd_addr returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'd0;
    else        rd_data <= buf_mem[rd_addr];
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam int CLK_FREQ = 1000000;
  localparam int UART_BPS = 100000;
  localparam int TC       = 3 * 10 * (CLK_FREQ / UART_BPS);

  logic       clk;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [7:0] frame_cmd;
  logic [4:0] frame_len;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_frame_parser #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS),
    .HEADER(8'hA5),
    .MAX_LEN(16),
    .TIMEOUT_BYTES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .frame_valid(frame_valid),
    .frame_cmd(frame_cmd),
    .frame_len(frame_len),
    .frame_err(frame_err),
    .err_code(err_code),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       e;
    logic [7:0] cmd;
    logic [4:0] len;
    logic [1:0] code;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int tests;
  int fails;

  logic [7:0] mdl_cmd;
  logic [4:0] mdl_len;
  logic [1:0] mdl_code;

  // Record every strobe cycle the DUT produces.
  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_err))
      obs_q.push_back({frame_valid, frame_err, frame_cmd, frame_len, err_code});
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic expect_valid(input logic [7:0] c, input logic [4:0] l);
    mdl_cmd = c;
    mdl_len = l;
    exp_q.push_back({1'b1, 1'b0, mdl_cmd, mdl_len, mdl_code});
  endtask

  task automatic expect_err(input logic [1:0] code);
    mdl_code = code;
    exp_q.push_back({1'b0, 1'b1, mdl_cmd, mdl_len, mdl_code});
  endtask

  // Pair off expected and observed strobe events for the scenario just run.
  task automatic drain(input string name);
    ev_t e, o;
    repeat (3) @(posedge clk);
    #1;
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      tests++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front();
        fails++;
        $display("FAIL %s missing event: got none, expected v=%0b e=%0b cmd=%h len=%0d code=%0d",
                 name, e.v, e.e, e.cmd, e.len, e.code);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front();
        fails++;
        $display("FAIL %s unexpected event: got v=%0b e=%0b cmd=%h len=%0d code=%0d, expected none",
                 name, o.v, o.e, o.cmd, o.len, o.code);
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL %s event: got v=%0b e=%0b cmd=%h len=%0d code=%0d, expected v=%0b e=%0b cmd=%h len=%0d code=%0d",
                   name, o.v, o.e, o.cmd, o.len, o.code, e.v, e.e, e.cmd, e.len, e.code);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({rd_data, frame_valid, frame_cmd, frame_len, frame_err, err_code, busy} !== 26'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rd=%h v=%b cmd=%h len=%0d e=%b code=%0d busy=%b, expected all 0",
               rd_data, frame_valid, frame_cmd, frame_len, frame_err, err_code, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl_cmd = 8'd0; mdl_len = 5'd0; mdl_code = 2'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_valid_frame();
    logic [7:0] pay [3];
    pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_idle: got %b, expected 0", busy); end
    send_byte(8'hA5);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_rise: got %b, expected 1", busy); end
    send_byte(8'h01);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_byte(pay[i]);
    expect_valid(8'h01, 5'd3);
    send_byte(8'h64);
    tests++;
    if (frame_valid !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL valid_edge: got valid=%b busy=%b, expected valid=1 busy=0", frame_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 4'(i);
      @(posedge clk);
      #1;
      tests++;
      if (rd_data !== pay[i]) begin
        fails++;
        $display("FAIL rd_data[%0d]: got %h, expected %h", i, rd_data, pay[i]);
      end
    end
    drain("valid_frame");
  endtask

  task automatic test_bad_checksum();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    expect_err(2'd1);
    send_byte(8'h65);
    tests++;
    if (frame_err !== 1'b1 || err_code !== 2'd1) begin
      fails++;
      $display("FAIL bad_chk_edge: got err=%b code=%0d, expected err=1 code=1", frame_err, err_code);
    end
    drain("bad_checksum");
  endtask

  task automatic test_oversize();
    send_byte(8'hA5); send_byte(8'h07);
    expect_err(2'd2);
    send_byte(8'h11);
    tests++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL oversize_edge: got err=%b code=%0d busy=%b, expected err=1 code=2 busy=0",
               frame_err, err_code, busy);
    end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    expect_valid(8'h02, 5'd0);
    send_byte(8'h02);
    drain("oversize");
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [7];
    seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h02};
    expect_valid(8'h02, 5'd0);
    rx_done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rx_data = seq[i];
      @(posedge clk);
      #1;
    end
    rx_done = 1'b0;
    drain("back_to_back");
  endtask

  task automatic test_timeout();
    send_byte(8'hA5); send_byte(8'h01);
    expect_err(2'd3);
    repeat (TC - 1) @(posedge clk);
    #1;
    tests++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL timeout_early: got err=%b, expected 0", frame_err); end
    @(posedge clk);
    #1;
    tests++;
    if (frame_err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_edge: got err=%b code=%0d busy=%b, expected err=1 code=3 busy=0",
               frame_err, err_code, busy);
    end
    drain("timeout");
    // Byte arriving exactly on the expiry cycle keeps the frame alive.
    send_byte(8'hA5); send_byte(8'h01);
    repeat (TC - 1) @(posedge clk);
    #1;
    send_byte(8'h00);
    tests++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_coincide: got err=%b busy=%b, expected err=0 busy=1", frame_err, busy);
    end
    expect_valid(8'h01, 5'd0);
    send_byte(8'h01);
    drain("timeout_coincide");
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h10);
    test_reset();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h7E);
    expect_valid(8'h03, 5'd1);
    send_byte(8'h82);
    rd_addr = 4'd0;
    @(posedge clk);
    #1;
    tests++;
    if (rd_data !== 8'h7E) begin fails++; $display("FAIL reset_recover_rd: got %h, expected 7e", rd_data); end
    tests++;
    if (frame_cmd !== 8'h03 || frame_len !== 5'd1) begin
      fails++;
      $display("FAIL reset_recover_frame: got cmd=%h len=%0d, expected cmd=03 len=1", frame_cmd, frame_len);
    end
    drain("reset_mid_frame");
  endtask

  initial begin
    tests = 0; fails = 0;
    rx_done = 1'b0; rx_data = 8'd0; rd_addr = 4'd0; rst_n = 1'b1;
    mdl_cmd = 8'd0; mdl_len = 5'd0; mdl_code = 2'd0;
    #2;
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_oversize();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
